// File: rtl/game_state_controller.sv
// Game-flow FSM: lives, level, freeze, respawn and game-over, all registered one cycle after the acting input edge.
// Optional bonus life on every BONUS_EVERY-th level is enabled by defining FROGGER_BONUS_LIFE_EN.
module game_state_controller #(
    parameter int LIVES_INI         = 3,
    parameter int START_LEVEL       = 1,
    parameter int MAX_LEVEL         = 9,
    parameter int HIT_FREEZE_CYCLES = 12_500_000,
    parameter int BONUS_EVERY       = 3
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Start,
    input  logic       i_Has_Collided,
    input  logic       i_Frog_Home,
    output logic [2:0] o_State,
    output logic [2:0] o_Lives,
    output logic [3:0] o_Level,
    output logic       o_Freeze,
    output logic       o_Respawn,
    output logic       o_Game_Over
);

    localparam int TW = $clog2(HIT_FREEZE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(HIT_FREEZE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY     = 3'd1,
        S_HIT      = 3'd2,
        S_LEVEL_UP = 3'd3,
        S_OVER     = 3'd4
    } state_t;

    state_t        state_q;
    logic [2:0]    lives_q;
    logic [3:0]    level_q;
    logic [TW-1:0] timer_q;
    logic          freeze_q;
    logic          respawn_q;
    logic          game_over_q;
    logic          start_prev_q;
    logic          coll_prev_q;
    logic          home_prev_q;

    logic          start_rise;
    logic          coll_rise;
    logic          home_rise;
    logic [3:0]    level_d;
    logic [2:0]    lives_d;

    assign start_rise = i_Start & ~start_prev_q;
    assign coll_rise  = i_Has_Collided & ~coll_prev_q;
    assign home_rise  = i_Frog_Home & ~home_prev_q;

    always_comb begin
        level_d = level_q;
        lives_d = lives_q;
        if (level_q < 4'(MAX_LEVEL)) begin
            level_d = level_q + 4'd1;
`ifdef FROGGER_BONUS_LIFE_EN
            if (((32'(level_q) + 32'd1) % 32'(BONUS_EVERY)) == 32'd0 && lives_q != 3'd7)
                lives_d = lives_q + 3'd1;
`endif
        end
    end

`ifndef FROGGER_BONUS_LIFE_EN
    logic unused_bonus_every;
    assign unused_bonus_every = ^BONUS_EVERY;
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            lives_q      <= 3'(LIVES_INI);
            level_q      <= 4'(START_LEVEL);
            timer_q      <= '0;
            freeze_q     <= 1'b1;
            respawn_q    <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
            coll_prev_q  <= 1'b0;
            home_prev_q  <= 1'b0;
        end else begin
            start_prev_q <= i_Start;
            coll_prev_q  <= i_Has_Collided;
            home_prev_q  <= i_Frog_Home;
            respawn_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    freeze_q    <= 1'b1;
                    game_over_q <= 1'b0;
                    if (start_rise) begin
                        state_q   <= S_PLAY;
                        respawn_q <= 1'b1;
                        freeze_q  <= 1'b0;
                    end
                end
                S_PLAY: begin
                    freeze_q <= 1'b0;
                    // collision takes priority; a simultaneous home edge is dropped
                    if (coll_rise) begin
                        freeze_q <= 1'b1;
                        if (lives_q > 3'd1) begin
                            lives_q <= lives_q - 3'd1;
                            timer_q <= TIMER_LOAD;
                            state_q <= S_HIT;
                        end else begin
                            lives_q     <= 3'd0;
                            state_q     <= S_OVER;
                            game_over_q <= 1'b1;
                        end
                    end else if (home_rise) begin
                        level_q  <= level_d;
                        lives_q  <= lives_d;
                        timer_q  <= TIMER_LOAD;
                        freeze_q <= 1'b1;
                        state_q  <= S_LEVEL_UP;
                    end
                end
                S_HIT, S_LEVEL_UP: begin
                    freeze_q <= 1'b1;
                    if (timer_q == '0) begin
                        state_q   <= S_PLAY;
                        respawn_q <= 1'b1;
                        freeze_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_OVER: begin
                    freeze_q    <= 1'b1;
                    game_over_q <= 1'b1;
                    if (start_rise) begin
                        state_q     <= S_IDLE;
                        lives_q     <= 3'(LIVES_INI);
                        level_q     <= 4'(START_LEVEL);
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    timer_q     <= '0;
                    freeze_q    <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_State     = state_q;
    assign o_Lives     = lives_q;
    assign o_Level     = level_q;
    assign o_Freeze    = freeze_q;
    assign o_Respawn   = respawn_q;
    assign o_Game_Over = game_over_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller with a 4-cycle freeze.
module tb_game_state_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       coll;
    logic       home;
    logic [2:0] state;
    logic [2:0] lives;
    logic [3:0] level;
    logic       freeze;
    logic       respawn;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    int lives_exp;
    int level_exp;
    int level_prev;

    game_state_controller #(
        .LIVES_INI        (3),
        .START_LEVEL      (1),
        .MAX_LEVEL        (9),
        .HIT_FREEZE_CYCLES(4),
        .BONUS_EVERY      (3)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_n),
        .i_Start       (start),
        .i_Has_Collided(coll),
        .i_Frog_Home   (home),
        .o_State       (state),
        .o_Lives       (lives),
        .o_Level       (level),
        .o_Freeze      (freeze),
        .o_Respawn     (respawn),
        .o_Game_Over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; coll = 1'b0; home = 1'b0;
        #12;
        check("rst_state", 8'(state), 8'd0);
        check("rst_lives", 8'(lives), 8'd3);
        check("rst_level", 8'(level), 8'd1);
        check("rst_freeze", 8'(freeze), 8'd1);
        check("rst_respawn", 8'(respawn), 8'd0);
        check("rst_game_over", 8'(game_over), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_state", 8'(state), 8'd0);

        // start game
        start = 1'b1;
        step();
        check("t1_state", 8'(state), 8'd1);
        check("t1_respawn", 8'(respawn), 8'd1);
        check("t1_lives", 8'(lives), 8'd3);
        check("t1_level", 8'(level), 8'd1);
        check("t1_freeze", 8'(freeze), 8'd0);
        start = 1'b0;
        step();
        check("t1_respawn_pulse", 8'(respawn), 8'd0);
        check("t1_state_hold", 8'(state), 8'd1);

        // collision held high for 20 cycles
        coll = 1'b1;
        step();
        check("t2_state_hit", 8'(state), 8'd2);
        check("t2_lives", 8'(lives), 8'd2);
        check("t2_freeze0", 8'(freeze), 8'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("t2_freeze_n", 8'(freeze), 8'd1);
            check("t2_state_n", 8'(state), 8'd2);
        end
        step();
        check("t2_back_play", 8'(state), 8'd1);
        check("t2_unfreeze", 8'(freeze), 8'd0);
        check("t2_respawn", 8'(respawn), 8'd1);
        for (int i = 0; i < 15; i++) step();
        check("t2_no_second_dec", 8'(lives), 8'd2);
        check("t2_still_play", 8'(state), 8'd1);
        check("t2_respawn_low", 8'(respawn), 8'd0);
        coll = 1'b0;
        step();

        // collisions down to game over
        coll = 1'b1;
        step();
        check("t3_lives1", 8'(lives), 8'd1);
        check("t3_hit", 8'(state), 8'd2);
        coll = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("t3_play", 8'(state), 8'd1);
        coll = 1'b1;
        step();
        check("t3_lives0", 8'(lives), 8'd0);
        check("t3_over", 8'(state), 8'd4);
        check("t3_game_over", 8'(game_over), 8'd1);
        check("t3_freeze", 8'(freeze), 8'd1);
        coll = 1'b0;
        step();
        check("t3_over_hold", 8'(state), 8'd4);
        start = 1'b1;
        step();
        check("t3_idle", 8'(state), 8'd0);
        check("t3_reload_lives", 8'(lives), 8'd3);
        check("t3_reload_level", 8'(level), 8'd1);
        check("t3_go_clear", 8'(game_over), 8'd0);
        start = 1'b0;
        step();
        check("t3_idle_hold", 8'(state), 8'd0);
        start = 1'b1;
        step();
        check("t3_replay", 8'(state), 8'd1);
        start = 1'b0;
        step();

        // ten level-ups
        lives_exp = 3;
        level_exp = 1;
        for (int k = 1; k <= 10; k++) begin
            level_prev = level_exp;
            if (level_exp < 9) level_exp = level_exp + 1;
`ifdef FROGGER_BONUS_LIFE_EN
            if (level_prev < 9 && (level_exp % 3) == 0 && lives_exp < 7) lives_exp = lives_exp + 1;
`endif
            home = 1'b1;
            step();
            check("t4_level", 8'(level), 8'(level_exp));
            check("t4_lives", 8'(lives), 8'(lives_exp));
            check("t4_state", 8'(state), 8'd3);
            home = 1'b0;
            if (k == 1) begin
                // collision edge during freeze must be ignored
                coll = 1'b1;
                step();
                coll = 1'b0;
                for (int i = 0; i < 3; i++) step();
                check("t4_ignore_coll", 8'(lives), 8'(lives_exp));
            end else begin
                for (int i = 0; i < 4; i++) step();
            end
            check("t4_play", 8'(state), 8'd1);
        end

        // simultaneous collision and home
        coll = 1'b1;
        home = 1'b1;
        step();
        check("t5_lives", 8'(lives), 8'(lives_exp - 1));
        check("t5_level", 8'(level), 8'd9);
        check("t5_state", 8'(state), 8'd2);
        coll = 1'b0;
        home = 1'b0;
        step();

        // async reset mid-HIT with timer at 2
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_state", 8'(state), 8'd0);
        check("t6_freeze", 8'(freeze), 8'd1);
        check("t6_lives", 8'(lives), 8'd3);
        check("t6_level", 8'(level), 8'd1);
        check("t6_respawn", 8'(respawn), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
